id_issue_stage: RTL and testbench
=================================

# id_issue_stage

Decode-to-execute issue stage of the uDLX pipeline: accepts one DLX instruction word plus register-file read data per cycle and decodes it into the ALU opcode and operand pair. It holds the result in a registered pipeline slot and hands it to the execute stage's ALU over a valid/ready handshake. It is the producer end of the ALU operand/opcode interface and provides stall (backpressure) and flush.

## Interface
Parameters:
- DATA_WIDTH, 32, operand and register data width
- OPCODE_WIDTH, 3, ALU opcode width
- REG_ADDR_WIDTH, 5, register index width

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode-side instruction present
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  DLX instruction word
- in_rs1_data  in  DATA_WIDTH  register-file data for instr[25:21]
- in_rs2_data  in  DATA_WIDTH  register-file data for instr[20:16]
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  issue slot holds a decoded instruction
- out_ready  in  1  execute stage consumes slot this cycle
- alu_opcode  out  OPCODE_WIDTH  ADD=0 SUB=1 AND=2 OR=3 MULT=4 DIV=5 CMP=6 NOT=7
- alu_data_in_a  out  DATA_WIDTH  operand A
- alu_data_in_b  out  DATA_WIDTH  operand B
- out_rd  out  REG_ADDR_WIDTH  destination register
- out_illegal  out  1  instruction not decodable
- out_div_zero  out  1  DIV with operand B == 0 (macro-dependent)

## Operation
- Decode fields: op=instr[31:26]. R-type (op=0x00): func=instr[10:0], rd=instr[15:11], A=rs1_data, B=rs2_data.
- R-type func map: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x0E MULT, 0x0F DIV, 0x28 CMP, 0x27 NOT.
- I-type: rd=instr[20:16], A=rs1_data, B=sign-extended instr[15:0] (bit 15 replicated to DATA_WIDTH).
- I-type op map: 0x08 ADDI→ADD, 0x0A SUBI→SUB, 0x0C ANDI→AND, 0x0D ORI→OR.
- Any other op/func: out_illegal=1, alu_opcode=ADD, out_rd=0, A=B=0 (r0 writeback is harmless).
- Slot load: accept = in_valid && in_ready. Decoded fields are registered on accept.
- Handshake: in_ready = (!out_valid || out_ready) && !flush. Slot payload is stable while out_valid && !out_ready.
- Next out_valid: flush→0; else accept→1; else out_ready→0; else hold.
- Simultaneous consume and accept: new instruction replaces slot, out_valid stays 1, no bubble.
- Flush: has priority over accept and consume. Held and incoming instructions are both dropped; out_valid=0 next cycle.

## Timing
- Latency: exactly 1 cycle from accept to out_valid; throughput 1 instruction/cycle when out_ready held 1.
- in_ready: combinational from out_valid, out_ready, flush. Other outputs: registered only.
- Reset: out_valid=0, alu_opcode=0, alu_data_in_a=0, alu_data_in_b=0, out_rd=0, out_illegal=0, out_div_zero=0. in_ready=1 after reset deasserts (flush=0).
- Reset mid-stall: slot content is lost; no output transfer occurs in the reset cycle.
- Payload registers: update only on accept; they hold stale values when out_valid=0.

## Configuration
- ISSUE_DIV_ZERO_CHECK_EN defined: on accept of DIV with B==0, out_div_zero=1 registered with the slot. Opcode and operands are still issued unchanged.
- Not defined: out_div_zero is constant 0; no comparator is built.

## Test plan
- Reset, then in_instr=0x00221820 (ADD r3,r1,r2), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, alu_opcode=0, A=5, B=7, out_rd=3, out_illegal=0.
- in_instr=0x2024FFFF (ADDI r4,r1,-1), rs1=10 -> alu_opcode=0, A=10, B=0xFFFFFFFF, out_rd=4.
- Hold out_ready=0 with slot full, present a new instr -> in_ready=0, payload unchanged for 5 cycles. Raise out_ready alongside a valid input -> back-to-back transfer, out_valid stays 1.
- in_instr=0xFC000000 -> out_illegal=1, alu_opcode=0, out_rd=0.
- Slot full and flush=1 with in_valid=1 -> out_valid=0 next cycle; the input is not accepted (in_ready=0).
- in_instr=0x0022280F (DIV r5,r1,r2), rs2=0 -> alu_opcode=5, out_div_zero=1 with ISSUE_DIV_ZERO_CHECK_EN defined, 0 without it.

Source files
------------

// File: rtl/id_issue_stage.sv
// uDLX decode-to-execute issue stage: decodes one instruction per cycle into a registered ALU slot.
// Optional macro ISSUE_DIV_ZERO_CHECK_EN adds the registered out_div_zero flag for DIV with B == 0.
module id_issue_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_WIDTH   = 3,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_instr,
    input  logic [DATA_WIDTH-1:0]     in_rs1_data,
    input  logic [DATA_WIDTH-1:0]     in_rs2_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OPCODE_WIDTH-1:0]   alu_opcode,
    output logic [DATA_WIDTH-1:0]     alu_data_in_a,
    output logic [DATA_WIDTH-1:0]     alu_data_in_b,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic                      out_illegal,
    output logic                      out_div_zero
);

    localparam logic [OPCODE_WIDTH-1:0] ALU_ADD  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] ALU_SUB  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] ALU_AND  = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] ALU_OR   = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] ALU_MULT = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] ALU_DIV  = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] ALU_CMP  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] ALU_NOT  = OPCODE_WIDTH'(7);

    function automatic logic signed [DATA_WIDTH-1:0] sext_imm16(input logic [15:0] imm);
        return {{(DATA_WIDTH-16){imm[15]}}, imm};
    endfunction

    logic [5:0]  op;
    logic [10:0] func;
    logic        accept;

    logic [OPCODE_WIDTH-1:0]          dec_opcode;
    logic signed [DATA_WIDTH-1:0]     dec_a, dec_b;
    logic [REG_ADDR_WIDTH-1:0]        dec_rd;
    logic                             dec_illegal;

    logic                             valid_d, valid_q;
    logic [OPCODE_WIDTH-1:0]          opcode_d, opcode_q;
    logic signed [DATA_WIDTH-1:0]     a_d, a_q, b_d, b_q;
    logic [REG_ADDR_WIDTH-1:0]        rd_d, rd_q;
    logic                             illegal_d, illegal_q;

    assign op       = in_instr[31:26];
    assign func     = in_instr[10:0];
    assign in_ready = (!valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        dec_opcode  = ALU_ADD;
        dec_a       = in_rs1_data;
        dec_b       = in_rs2_data;
        dec_rd      = REG_ADDR_WIDTH'(in_instr[15:11]);
        dec_illegal = 1'b0;
        if (op == 6'h00) begin
            case (func)
                11'h020: dec_opcode = ALU_ADD;
                11'h022: dec_opcode = ALU_SUB;
                11'h024: dec_opcode = ALU_AND;
                11'h025: dec_opcode = ALU_OR;
                11'h00E: dec_opcode = ALU_MULT;
                11'h00F: dec_opcode = ALU_DIV;
                11'h028: dec_opcode = ALU_CMP;
                11'h027: dec_opcode = ALU_NOT;
                default: dec_illegal = 1'b1;
            endcase
        end else begin
            dec_rd = REG_ADDR_WIDTH'(in_instr[20:16]);
            dec_b  = sext_imm16(in_instr[15:0]);
            case (op)
                6'h08:   dec_opcode = ALU_ADD;
                6'h0A:   dec_opcode = ALU_SUB;
                6'h0C:   dec_opcode = ALU_AND;
                6'h0D:   dec_opcode = ALU_OR;
                default: dec_illegal = 1'b1;
            endcase
        end
        // Undecodable words issue as a harmless ADD into r0.
        if (dec_illegal) begin
            dec_opcode = ALU_ADD;
            dec_a      = '0;
            dec_b      = '0;
            dec_rd     = '0;
        end
    end

    always_comb begin
        opcode_d  = accept ? dec_opcode  : opcode_q;
        a_d       = accept ? dec_a       : a_q;
        b_d       = accept ? dec_b       : b_q;
        rd_d      = accept ? dec_rd      : rd_q;
        illegal_d = accept ? dec_illegal : illegal_q;
        if (flush)          valid_d = 1'b0;
        else if (accept)    valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;
        else                valid_d = valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid     = valid_q;
    assign alu_opcode    = opcode_q;
    assign alu_data_in_a = a_q;
    assign alu_data_in_b = b_q;
    assign out_rd        = rd_q;
    assign out_illegal   = illegal_q;

`ifdef ISSUE_DIV_ZERO_CHECK_EN
    logic div_zero_d, div_zero_q;

    always_comb begin
        div_zero_d = div_zero_q;
        if (accept)
            div_zero_d = !dec_illegal && (dec_opcode == ALU_DIV) && (op == 6'h00)
                         && (in_rs2_data == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) div_zero_q <= 1'b0;
        else     div_zero_q <= div_zero_d;
    end

    assign out_div_zero = div_zero_q;
`else
    assign out_div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_id_issue_stage.sv
// Scoreboard bench for id_issue_stage: directed test-plan cases followed by random traffic.
module tb_id_issue_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_rs1_data, in_rs2_data;
    logic [2:0]  alu_opcode;
    logic [31:0] alu_data_in_a, alu_data_in_b;
    logic [4:0]  out_rd;
    logic        out_illegal, out_div_zero;

    always #5 clk = ~clk;

    id_issue_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_opcode(alu_opcode), .alu_data_in_a(alu_data_in_a), .alu_data_in_b(alu_data_in_b),
        .out_rd(out_rd), .out_illegal(out_illegal), .out_div_zero(out_div_zero)
    );

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        ill;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic started = 1'b0;
    logic cur_valid = 1'b0, nxt_valid = 1'b0, exp_ready = 1'b1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference decode, written straight from the instruction-set tables.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   code;
        int   fn;
        int   opc;
        e   = '0;
        opc = int'(ins[31:26]);
        fn  = int'(ins[10:0]);
        code = -1;
        if (opc == 0) begin
            case (fn)
                'h20: code = 0;  'h22: code = 1;  'h24: code = 2;  'h25: code = 3;
                'h0E: code = 4;  'h0F: code = 5;  'h28: code = 6;  'h27: code = 7;
                default: code = -1;
            endcase
            e.rd = ins[15:11];
            e.a  = a;
            e.b  = b;
        end else begin
            case (opc)
                'h08: code = 0;  'h0A: code = 1;  'h0C: code = 2;  'h0D: code = 3;
                default: code = -1;
            endcase
            e.rd = ins[20:16];
            e.a  = a;
            e.b  = 32'(int'($signed(ins[15:0])));
        end
        if (code < 0) begin
            e     = '0;
            e.ill = 1'b1;
        end else begin
            e.op = 3'(code);
`ifdef ISSUE_DIV_ZERO_CHECK_EN
            e.dz = (code == 5) && (b == 0);
`endif
        end
        return e;
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b, input logic rdy, input logic fl, input logic r);
        logic acc;
        @(posedge clk);
        #1;
        cur_valid   = nxt_valid;
        in_valid    = v;
        in_instr    = ins;
        in_rs1_data = a;
        in_rs2_data = b;
        out_ready   = rdy;
        flush       = fl;
        rst         = r;
        if (r) begin
            sb.delete();
            nxt_valid = 1'b0;
        end else begin
            exp_ready = (!cur_valid || rdy) && !fl;
            acc       = v && exp_ready;
            if (fl)       sb.delete();
            else if (acc) sb.push_back(model(ins, a, b));
            nxt_valid = fl ? 1'b0 : acc ? 1'b1 : rdy ? 1'b0 : cur_valid;
        end
    endtask

    // Monitor: checks handshake every cycle and the slot against the scoreboard head.
    always @(negedge clk) begin
        exp_t got;
        if (started && !rst) begin
            chk("in_ready", 128'(in_ready), 128'(exp_ready));
            chk("out_valid", 128'(out_valid), 128'(cur_valid));
            if (out_valid && !flush) begin
                got = '{op: alu_opcode, a: alu_data_in_a, b: alu_data_in_b, rd: out_rd,
                        ill: out_illegal, dz: out_div_zero};
                if (sb.size() == 0) begin
                    chk("slot_unexpected", 128'(got), 128'(0) - 1);
                end else begin
                    chk("slot_payload", 128'(got), 128'(sb[0]));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [10:0] funcs [8] = '{11'h020, 11'h022, 11'h024, 11'h025, 11'h00E, 11'h00F, 11'h028, 11'h027};
        logic [5:0]  iops  [4] = '{6'h08, 6'h0A, 6'h0C, 6'h0D};
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0, 1: w = {6'h00, w[25:11], funcs[$urandom_range(0, 7)]};
            2:    w = {iops[$urandom_range(0, 3)], w[25:0]};
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        logic [31:0] b;
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_rs1_data = '0; in_rs2_data = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_alu_opcode", 128'(alu_opcode), 128'(0));
        chk("rst_a", 128'(alu_data_in_a), 128'(0));
        chk("rst_b", 128'(alu_data_in_b), 128'(0));
        chk("rst_rd", 128'(out_rd), 128'(0));
        chk("rst_illegal", 128'(out_illegal), 128'(0));
        chk("rst_div_zero", 128'(out_div_zero), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        started = 1'b1;

        step(1, 32'h00221820, 32'd5, 32'd7, 1, 0, 0);            // ADD r3,r1,r2
        step(1, 32'h2024FFFF, 32'd10, 32'd99, 1, 0, 0);          // ADDI r4,r1,-1
        repeat (5) step(1, 32'h00221822, 32'd1, 32'd2, 0, 0, 0); // stall
        step(1, 32'hFC000000, 32'd3, 32'd4, 1, 0, 0);            // back-to-back, illegal
        step(1, 32'h0022280F, 32'd9, 32'd0, 1, 0, 0);            // DIV by zero
        step(1, 32'h00221820, 32'd1, 32'd2, 0, 0, 0);
        step(1, 32'h00221820, 32'd1, 32'd2, 0, 1, 0);            // flush full slot
        step(0, 32'h0, 32'd0, 32'd0, 1, 0, 0);
        step(1, 32'h00221824, 32'd6, 32'd3, 1, 0, 0);
        step(0, 32'h0, 32'd0, 32'd0, 0, 0, 0);                   // held slot
        step(0, 32'h0, 32'd0, 32'd0, 0, 0, 1);                   // reset mid-stall
        step(0, 32'h0, 32'd0, 32'd0, 1, 0, 0);

        for (int i = 0; i < 600; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom, b,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 99) == 0);
        end
        step(0, 32'h0, 32'd0, 32'd0, 1, 0, 0);
        step(0, 32'h0, 32'd0, 32'd0, 1, 0, 0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
